// File: rtl/cp0_if.sv
// cp0_if: M-stage <-> CP0 bus; master is the pipeline, slave is cp0_unit.
interface cp0_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret_in;
  logic        req;
  logic [31:0] epc_out;
  modport master (output we, addr, wdata, vpc, bd_in, exc_code_in, hw_int, eret_in,
                  input rdata, req, epc_out);
  modport slave  (input we, addr, wdata, vpc, bd_in, exc_code_in, hw_int, eret_in,
                  output rdata, req, epc_out);
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 exception/interrupt controller (SR, Cause, EPC, PRId); redirects fetch via req.
// Optional CP0_EPC_BYPASS_EN forwards an in-flight mtc0 EPC straight to epc_out.
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h0000_4341
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);
  logic [5:0]  r_im, r_ip;
  logic        r_exl, r_ie, r_bd;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;
  logic        w_int_pend, w_exc_pend, w_req;
  logic [31:0] w_rdata;
  assign w_int_pend = |(bus.hw_int & r_im) & r_ie & ~r_exl;
  assign w_exc_pend = (bus.exc_code_in != 5'd0) & ~r_exl;
  assign w_req      = reset & (w_int_pend | w_exc_pend);
  assign bus.req    = w_req;
  always_comb begin
    w_rdata = bus.addr == 5'd12 ? {16'b0, r_im, 8'b0, r_exl, r_ie} :
              bus.addr == 5'd13 ? {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0} :
              bus.addr == 5'd14 ? r_epc :
              bus.addr == 5'd15 ? PRID_VAL : 32'b0;
  end
  assign bus.rdata = w_rdata;
`ifdef CP0_EPC_BYPASS_EN
  assign bus.epc_out = (bus.we && bus.addr == 5'd14 && !w_req) ? bus.wdata : r_epc;
`else
  assign bus.epc_out = r_epc;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= bus.hw_int;
      if (w_req) begin
        r_exl <= 1'b1;
        r_bd  <= bus.bd_in;
        r_exc <= w_int_pend ? 5'd0 : bus.exc_code_in;
        r_epc <= bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
      end else begin
        if (bus.we && bus.addr == 5'd12) begin
          r_im  <= bus.wdata[15:10];
          r_exl <= bus.wdata[1];
          r_ie  <= bus.wdata[0];
        end
        // eret must override any EXL value written by a same-cycle mtc0 SR
        if (bus.eret_in) r_exl <= 1'b0;
        if (bus.we && bus.addr == 5'd14) r_epc <= bus.wdata;
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scoreboard bench for cp0_unit.
module tb_cp0_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  cp0_if bus();
  cp0_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: got %h expected an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask
  task automatic chk_req(input string t, input logic v);
    push(t, {31'b0, v});
    #1;
    pop_chk({31'b0, bus.req});
  endtask
  task automatic chk_epc(input string t, input logic [31:0] v);
    push(t, v);
    #1;
    pop_chk(bus.epc_out);
  endtask
  task automatic rd(input string t, input logic [4:0] a, input logic [31:0] v);
    bus.addr = a;
    push(t, v);
    #1;
    pop_chk(bus.rdata);
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    reset = 1'b0;
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.vpc = '0; bus.bd_in = 1'b0;
    bus.exc_code_in = 5'd4; bus.hw_int = 6'h3F; bus.eret_in = 1'b0;
    chk_req("rst_req", 1'b0);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_prid", 5'd15, 32'h0000_4341);
    chk_epc("rst_epc_out", 32'h0);
    step();
    bus.exc_code_in = '0; bus.hw_int = '0;
    reset = 1'b1;
    bus.we = 1'b1; bus.addr = 5'd12; bus.wdata = 32'hFFFF_FFFE;
    step();
    bus.we = 1'b0;
    rd("sr_mask", 5'd12, 32'h0000_FC02);
    bus.we = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_0401;
    step();
    bus.we = 1'b0;
    rd("sr_write", 5'd12, 32'h0000_0401);
    bus.hw_int = 6'h01; bus.vpc = 32'h3010; bus.bd_in = 1'b0;
    chk_req("int_req", 1'b1);
    step();
    chk_req("exl_mask_req", 1'b0);
    rd("int_epc", 5'd14, 32'h3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    chk_epc("int_epc_out", 32'h3010);
    bus.eret_in = 1'b1;
    chk_req("eret_exl_req", 1'b0);
    step();
    bus.eret_in = 1'b0; bus.vpc = 32'h3040;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk_req("post_eret_req", 1'b1);
    step();
    rd("post_eret_epc", 5'd14, 32'h3040);
    bus.hw_int = '0; bus.eret_in = 1'b1;
    step();
    bus.eret_in = 1'b0;
    bus.exc_code_in = 5'd10; bus.vpc = 32'h3024; bus.bd_in = 1'b1;
    chk_req("exc_req", 1'b1);
    step();
    bus.exc_code_in = '0; bus.bd_in = 1'b0;
    rd("exc_cause", 5'd13, 32'h8000_0028);
    rd("exc_epc_bd", 5'd14, 32'h3020);
    bus.eret_in = 1'b1;
    step();
    bus.eret_in = 1'b0;
    bus.hw_int = 6'h01; bus.exc_code_in = 5'd4; bus.vpc = 32'h3050;
    bus.we = 1'b1; bus.addr = 5'd14; bus.wdata = 32'hDEAD_BEEF;
    chk_req("both_req", 1'b1);
    step();
    bus.we = 1'b0; bus.exc_code_in = '0; bus.hw_int = '0;
    rd("both_epc", 5'd14, 32'h3050);
    rd("both_cause", 5'd13, 32'h0000_0400);
    bus.eret_in = 1'b1;
    step();
    bus.hw_int = 6'h01; bus.vpc = 32'h3060;
    chk_req("eret_int_req", 1'b1);
    step();
    bus.hw_int = '0; bus.eret_in = 1'b0;
    rd("eret_int_sr", 5'd12, 32'h0000_0403);
    rd("eret_int_epc", 5'd14, 32'h3060);
    bus.eret_in = 1'b1;
    step();
    bus.we = 1'b1; bus.addr = 5'd14; bus.wdata = 32'h3100;
    chk_req("byp_req", 1'b0);
`ifdef CP0_EPC_BYPASS_EN
    chk_epc("byp_epc_out", 32'h3100);
`else
    chk_epc("byp_epc_out", 32'h3060);
`endif
    rd("no_write_through", 5'd14, 32'h3060);
    step();
    bus.we = 1'b0; bus.eret_in = 1'b0;
    rd("mtc0_epc", 5'd14, 32'h3100);
    rd("sr_after_eret", 5'd12, 32'h0000_0401);
    bus.we = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h0000_0403; bus.eret_in = 1'b1;
    step();
    bus.we = 1'b0; bus.eret_in = 1'b0;
    rd("eret_beats_sr_exl", 5'd12, 32'h0000_0401);
    bus.we = 1'b1; bus.addr = 5'd13; bus.wdata = 32'hFFFF_FFFF;
    step();
    bus.we = 1'b0;
    rd("cause_ro", 5'd13, 32'h0);
    rd("unmapped", 5'd5, 32'h0);
    bus.exc_code_in = 5'd12; bus.vpc = 32'h3200;
    step();
    chk_req("nested_req", 1'b0);
    rd("mid_epc", 5'd14, 32'h3200);
    reset = 1'b0;
    chk_req("async_rst_req", 1'b0);
    chk_epc("async_rst_epc", 32'h0);
    rd("async_rst_sr", 5'd12, 32'h0);
    step();
    reset = 1'b1;
    chk_req("post_rst_req", 1'b1);
    step();
    bus.exc_code_in = '0;
    rd("post_rst_epc", 5'd14, 32'h3200);
    if (sb.size() != 0) begin
      n_bad++;
      $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
